// File: rtl/gate_tt_checker_pkg.sv
// Shared types and constants for the truth-table checker.
// Holds FSM state encoding and reference truth tables.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XNOR = 4'b1001;

    localparam int unsigned HOLD_W = 8;

    function automatic logic tt_bit(
        input logic [3:0] tt,
        input logic [1:0] idx
    );
        return tt[idx];
    endfunction

endpackage

// File: rtl/gate_tt_checker_if.sv
// Control and gate-side signals of the truth-table checker.
// master = checker, slave = gate under test plus controller.
interface gate_tt_checker_if;
    logic       start;
    logic       y;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_vec;
    logic [2:0] err_count;

    modport master (
        input  start, y,
        output a, b, busy, done, pass, fail_vec, err_count
    );

    modport slave (
        output start, y,
        input  a, b, busy, done, pass, fail_vec, err_count
    );
endinterface

// File: rtl/gate_tt_checker_timer.sv
// Down-counting hold timer: load, count down, flag when at zero.
// Parked at zero after reset, so it reads as expired when idle.
module gate_chk_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/gate_tt_checker.sv
// Drives all four {a,b} vectors into a 2-input gate and scores
// its output y against the expected truth table EXPECT_TT.
module gate_tt_checker
    import gate_chk_pkg::*;
#(
    parameter logic [3:0]  EXPECT_TT   = TT_AND,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input logic clk,
    input logic rst,
    gate_tt_checker_if.master bus
);

    localparam logic [HOLD_W-1:0] HOLD_LD = HOLD_W'(HOLD_CYCLES - 1);

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] vec_q, vec_d;
    logic       pass_q, pass_d;
    logic [3:0] fv_q, fv_d;
    logic [2:0] err_q, err_d;

    logic tmr_load;
    logic tmr_en;
    logic tmr_exp;
    logic mism;

    gate_chk_timer #(.W(HOLD_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (HOLD_LD),
        .en_i       (tmr_en),
        .expired_o  (tmr_exp)
    );

    assign mism = (bus.y != tt_bit(EXPECT_TT, idx_q));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        vec_d    = vec_q;
        pass_d   = pass_q;
        fv_d     = fv_q;
        err_d    = err_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_DRIVE;
                    idx_d    = 2'd0;
                    vec_d    = 2'd0;
                    fv_d     = 4'd0;
                    err_d    = 3'd0;
                    tmr_load = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (tmr_exp) begin
                    state_d = ST_SAMPLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (mism) begin
                    fv_d[idx_q] = 1'b1;
                    if (err_q != 3'd4) begin
                        err_d = err_q + 3'd1;
                    end
                end
                // pass must reflect this final sample, so use err_d
                if (idx_q == 2'd3) begin
                    state_d = ST_DONE;
                    pass_d  = (err_d == 3'd0);
                end else begin
                    state_d  = ST_DRIVE;
                    idx_d    = idx_q + 2'd1;
                    vec_d    = idx_q + 2'd1;
                    tmr_load = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            vec_q   <= 2'd0;
            pass_q  <= 1'b0;
            fv_q    <= 4'd0;
            err_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            pass_q  <= pass_d;
            fv_q    <= fv_d;
            err_q   <= err_d;
        end
    end

    assign bus.a         = vec_q[1];
    assign bus.b         = vec_q[0];
    assign bus.busy      = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.pass      = pass_q;
    assign bus.fail_vec  = fv_q;
    assign bus.err_count = err_q;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Directed bench for gate_tt_checker with three configurations.
// Gate models are selectable per instance.
module tb_gate_tt_checker;
    import gate_chk_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   mode0, mode1, mode2;
    int   dn0 = 0, dn1 = 0, dn2 = 0;
    int   base;

    always #5 clk = ~clk;

    gate_tt_checker_if if0 ();
    gate_tt_checker_if if1 ();
    gate_tt_checker_if if2 ();

    gate_tt_checker #(.EXPECT_TT(TT_AND), .HOLD_CYCLES(2)) u0 (
        .clk (clk), .rst (rst), .bus (if0)
    );
    gate_tt_checker #(.EXPECT_TT(TT_AND), .HOLD_CYCLES(1)) u1 (
        .clk (clk), .rst (rst), .bus (if1)
    );
    gate_tt_checker #(.EXPECT_TT(TT_XNOR), .HOLD_CYCLES(2)) u2 (
        .clk (clk), .rst (rst), .bus (if2)
    );

    // 0 AND, 1 OR, 2 tied low, 3 XNOR
    function automatic logic gate(input int m, input logic a, input logic b);
        case (m)
            0:       return a & b;
            1:       return a | b;
            3:       return ~(a ^ b);
            default: return 1'b0;
        endcase
    endfunction

    assign if0.y = gate(mode0, if0.a, if0.b);
    assign if1.y = gate(mode1, if1.a, if1.b);
    assign if2.y = gate(mode2, if2.a, if2.b);

    always @(posedge clk) begin
        if (if0.done) dn0 <= dn0 + 1;
        if (if1.done) dn1 <= dn1 + 1;
        if (if2.done) dn2 <= dn2 + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        if0.start = 1'b0;
        if1.start = 1'b0;
        if2.start = 1'b0;
        mode0 = 0;
        mode1 = 0;
        mode2 = 2;
        repeat (3) tick();
        check("rst_u0", {if0.a, if0.b, if0.busy, if0.done, if0.pass,
                         if0.fail_vec, if0.err_count}, 0);
        check("rst_u1", {if1.a, if1.b, if1.busy, if1.done, if1.pass,
                         if1.fail_vec, if1.err_count}, 0);
        check("rst_u2", {if2.a, if2.b, if2.busy, if2.done, if2.pass,
                         if2.fail_vec, if2.err_count}, 0);
        rst = 1'b0;
        tick();

        // AND gate, full passing run
        base = dn0;
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        check("s1_ab_e1", {if0.a, if0.b}, 0);
        check("s1_busy", if0.busy, 1);
        for (int e = 2; e <= 14; e++) begin
            tick();
            if (e == 3) check("s1_hold_smp", {if0.a, if0.b}, 0);
            if (e == 4 || e == 7 || e == 10)
                check("s1_ab", {if0.a, if0.b}, (e - 1) / 3);
            if (e == 12) check("s1_nodone12", if0.done, 0);
            if (e == 13) begin
                check("s1_done", if0.done, 1);
                check("s1_pass", if0.pass, 1);
                check("s1_err", if0.err_count, 0);
                check("s1_fv", if0.fail_vec, 4'b0000);
            end
            if (e == 14) check("s1_ab_idle", {if0.a, if0.b, if0.busy}, 3'b110);
        end
        check("s1_ndone", dn0 - base, 1);

        // OR gate against AND table
        mode0 = 1;
        base = dn0;
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        for (int e = 2; e <= 14; e++) begin
            tick();
            if (e == 5) check("s2_pass_hold", if0.pass, 1);
            if (e == 13) begin
                check("s2_done", if0.done, 1);
                check("s2_fv", if0.fail_vec, 4'b0110);
                check("s2_err", if0.err_count, 2);
                check("s2_pass", if0.pass, 0);
            end
        end
        check("s2_ndone", dn0 - base, 1);

        // start re-pulsed during vector 1 is ignored
        mode0 = 0;
        base = dn0;
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        check("s3_fv_clr", {if0.fail_vec, if0.err_count}, 0);
        for (int e = 2; e <= 24; e++) begin
            tick();
            if (e == 4) if0.start = 1'b1;
            if (e == 5) if0.start = 1'b0;
            if (e == 7 || e == 10)
                check("s3_ab", {if0.a, if0.b}, (e - 1) / 3);
            if (e == 13) check("s3_done_pass", {if0.done, if0.pass}, 2'b11);
        end
        check("s3_ndone", dn0 - base, 1);
        check("s3_idle", if0.busy, 0);

        // reset during vector 2
        base = dn0;
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        for (int e = 2; e <= 8; e++) tick();
        check("s4_ab_v2", {if0.a, if0.b}, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s4_rst", {if0.a, if0.b, if0.busy, if0.done, if0.pass,
                         if0.fail_vec, if0.err_count}, 0);
        repeat (10) tick();
        check("s4_nodone", dn0 - base, 0);
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        check("s4_ab_e1", {if0.a, if0.b, if0.busy}, 3'b001);
        for (int e = 2; e <= 14; e++) begin
            tick();
            if (e == 10) check("s4_ab_v3", {if0.a, if0.b}, 3);
            if (e == 13) begin
                check("s4_done_pass", {if0.done, if0.pass}, 2'b11);
                check("s4_fv_err", {if0.fail_vec, if0.err_count}, 0);
            end
        end
        check("s4_ndone", dn0 - base, 1);

        // HOLD=1, start held high: back-to-back runs
        base = dn1;
        if1.start = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            check("s5_done", if1.done, (e % 10) == 9);
            if (if1.done) check("s5_pass", if1.pass, 1);
            if (e == 40) if1.start = 1'b0;
        end
        repeat (12) tick();
        check("s5_ndone", dn1 - base, 4);

        // tied-low gate against XNOR table, then a passing XNOR run
        base = dn2;
        if2.start = 1'b1;
        tick();
        if2.start = 1'b0;
        repeat (12) tick();
        check("s6_done", if2.done, 1);
        check("s6_fv", if2.fail_vec, 4'b1001);
        check("s6_err", if2.err_count, 2);
        check("s6_pass", if2.pass, 0);
        tick();
        mode2 = 3;
        if2.start = 1'b1;
        tick();
        if2.start = 1'b0;
        repeat (12) tick();
        check("s6b_done", if2.done, 1);
        check("s6b_pass", if2.pass, 1);
        check("s6b_fv", if2.fail_vec, 4'b0000);
        check("s6b_err", if2.err_count, 0);
        tick();
        check("s6_ndone", dn2 - base, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
